// File: rtl/pool_pkg.sv
// Shared pooling definitions: default window geometry, packed window width and
// the element index used to place window element (r,c) in a packed word.
package pool_pkg;

  localparam int FILTER_SIZE_DEF = 5;
  localparam int DATA_BITS_DEF   = 8;
  localparam int WIN_BITS        = FILTER_SIZE_DEF * FILTER_SIZE_DEF * DATA_BITS_DEF;

  typedef enum logic {
    BAND_FILL = 1'b0,
    BAND_LAST = 1'b1
  } band_e;

  function automatic int win_idx(input int r, input int c, input int f);
    return r * f + c;
  endfunction

endpackage

// File: rtl/pool_line_mem.sv
// Line store for the first FILTER_SIZE-1 rows of a band: one synchronous write
// port, FILTER_SIZE-1 combinational read ports sharing one column address.
module pool_line_mem #(
  parameter int FILTER_SIZE = 5,
  parameter int DATA_BITS   = 8,
  parameter int IMG_WIDTH   = 30,
  localparam int SW = (FILTER_SIZE > 2) ? $clog2(FILTER_SIZE - 1) : 1,
  localparam int CW = $clog2(IMG_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [SW-1:0]                        wr_slot,
  input  logic [CW-1:0]                        wr_col,
  input  logic [DATA_BITS-1:0]                 wr_data,
  input  logic [CW-1:0]                        rd_col,
  output logic [(FILTER_SIZE-1)*DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**SW][IMG_WIDTH];

  // Stored rows of the current column, row 0 in the low bits.
  always_comb begin
    rd_data = '0;
    for (int s = 0; s < FILTER_SIZE - 1; s++) begin
      rd_data[s*DATA_BITS +: DATA_BITS] = mem[SW'(s)][rd_col];
    end
  end

  // Pixel write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_slot][wr_col] <= wr_data;
    end
  end

endmodule

// File: rtl/pool_window_buffer.sv
// Raster pixel stream to non-overlapping FILTER_SIZE x FILTER_SIZE windows,
// one packed window per valid/ready transfer.
module pool_window_buffer
  import pool_pkg::*;
#(
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int IMG_WIDTH   = 30,
  parameter int IMG_HEIGHT  = 30
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       in_sof,
  input  logic [DATA_BITS-1:0]                       in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] out_window,
  output logic                                       frame_done
);

  localparam int WB    = FILTER_SIZE * FILTER_SIZE * DATA_BITS;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int BW    = $clog2(FILTER_SIZE);
  localparam int SW    = (FILTER_SIZE > 2) ? $clog2(FILTER_SIZE - 1) : 1;
  localparam int ACT_W = (IMG_WIDTH / FILTER_SIZE) * FILTER_SIZE;
  localparam int ACT_H = (IMG_HEIGHT / FILTER_SIZE) * FILTER_SIZE;

  logic [CW-1:0] col, eff_col, col_next;
  logic [RW-1:0] row, eff_row, row_next;
  logic [BW-1:0] cb, eff_cb, cb_next;
  logic [BW-1:0] rb, eff_rb, rb_next;
  logic [WB-1:0] asm_win, asm_next;
  logic [(FILTER_SIZE-1)*DATA_BITS-1:0] rd_data;
  logic in_fire, active, last_pix, load, mem_we;
  band_e band;

  assign in_ready = ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign mem_we   = in_fire & active & (band == BAND_FILL);

  // Position of the offered pixel; a start-of-frame pixel is forced to the origin.
  always_comb begin
    eff_col = in_sof ? '0 : col;
    eff_row = in_sof ? '0 : row;
    eff_cb  = in_sof ? '0 : cb;
    eff_rb  = in_sof ? '0 : rb;
    active   = ({1'b0, eff_col} < (CW+1)'(ACT_W)) && ({1'b0, eff_row} < (RW+1)'(ACT_H));
    band     = (eff_rb == BW'(FILTER_SIZE - 1)) ? BAND_LAST : BAND_FILL;
    last_pix = (eff_col == CW'(IMG_WIDTH - 1)) && (eff_row == RW'(IMG_HEIGHT - 1));
  end

  // Counter advance with mod-FILTER_SIZE sub-counters instead of dividers.
  always_comb begin
    col_next = eff_col + 1'b1;
    cb_next  = (eff_cb == BW'(FILTER_SIZE - 1)) ? '0 : eff_cb + 1'b1;
    row_next = eff_row;
    rb_next  = eff_rb;
    if (eff_col == CW'(IMG_WIDTH - 1)) begin
      col_next = '0;
      cb_next  = '0;
      if (eff_row == RW'(IMG_HEIGHT - 1)) begin
        row_next = '0;
        rb_next  = '0;
      end else begin
        row_next = eff_row + 1'b1;
        rb_next  = (eff_rb == BW'(FILTER_SIZE - 1)) ? '0 : eff_rb + 1'b1;
      end
    end else begin
      row_next = eff_row;
      rb_next  = eff_rb;
    end
  end

  // Last band row: stored column plus current pixel form window column cb.
  always_comb begin
    asm_next = asm_win;
    load     = 1'b0;
    if (in_fire && active && (band == BAND_LAST)) begin
      for (int r = 0; r < FILTER_SIZE - 1; r++) begin
        asm_next[win_idx(r, int'(eff_cb), FILTER_SIZE)*DATA_BITS +: DATA_BITS] =
          rd_data[r*DATA_BITS +: DATA_BITS];
      end
      asm_next[win_idx(FILTER_SIZE - 1, int'(eff_cb), FILTER_SIZE)*DATA_BITS +: DATA_BITS] = in_data;
      load = (eff_cb == BW'(FILTER_SIZE - 1));
    end else begin
      asm_next = asm_win;
      load     = 1'b0;
    end
  end

  pool_line_mem #(
    .FILTER_SIZE(FILTER_SIZE),
    .DATA_BITS  (DATA_BITS),
    .IMG_WIDTH  (IMG_WIDTH)
  ) u_line_mem (
    .clk    (clk),
    .we     (mem_we),
    .wr_slot(SW'(eff_rb)),
    .wr_col (eff_col),
    .wr_data(in_data),
    .rd_col (eff_col),
    .rd_data(rd_data)
  );

  // Pixel position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      cb  <= '0;
      rb  <= '0;
    end else if (in_fire) begin
      col <= col_next;
      row <= row_next;
      cb  <= cb_next;
      rb  <= rb_next;
    end
  end

  // Assembly register, output window holding stage and end-of-frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_win    <= '0;
      out_window <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      asm_win    <= asm_next;
      frame_done <= in_fire & last_pix;
      if (load) begin
        out_window <= asm_next;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Self-checking bench: three configurations driven by directed and random
// streams, checked cycle by cycle against a frame-array reference model.
module tb_pool_window_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic iv[3], is[3], orr[3], ir[3], ov[3], fd[3];
  logic [7:0]   id[3];
  logic [31:0]  ow0, ow1;
  logic [199:0] ow2;

  always #5 clk = ~clk;

  pool_window_buffer #(.FILTER_SIZE(2), .DATA_BITS(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_sof(is[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_window(ow0), .frame_done(fd[0]));
  pool_window_buffer #(.FILTER_SIZE(2), .DATA_BITS(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_sof(is[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_window(ow1), .frame_done(fd[1]));
  pool_window_buffer #(.FILTER_SIZE(5), .DATA_BITS(8), .IMG_WIDTH(30), .IMG_HEIGHT(30)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_sof(is[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_window(ow2), .frame_done(fd[2]));

  int total = 0;
  int bad = 0;
  int cur = 0, F = 2, W = 4, H = 4;
  int mode = 0, hold_left = 0;
  int pr = 0, pc = 0;
  bit hold_started = 1'b0, use_max = 1'b0;
  logic fd_exp = 1'b0;
  logic [7:0] img [30][30];
  logic [199:0] q[$];
  int mx_q[$];

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] obs_win();
    logic [199:0] w;
    w = '0;
    case (cur)
      0: w[31:0] = ow0;
      1: w[31:0] = ow1;
      default: w = ow2;
    endcase
    return w;
  endfunction

  function automatic int win_max(input logic [199:0] w);
    int m;
    logic signed [7:0] e;
    m = -129;
    for (int k = 0; k < F * F; k++) begin
      e = w[k*8 +: 8];
      if (int'(e) > m) m = int'(e);
    end
    return m;
  endfunction

  task automatic sel(input int k);
    cur = k;
    case (k)
      0: begin F = 2; W = 4; H = 4; end
      1: begin F = 2; W = 5; H = 5; end
      default: begin F = 5; W = 30; H = 30; end
    endcase
  endtask

  task automatic reset_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; is[k] = 1'b0; id[k] = 8'h00; orr[k] = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_out_valid", 200'(ov[cur]), 200'(0));
    check("rst_out_window", obs_win(), 200'(0));
    check("rst_frame_done", 200'(fd[cur]), 200'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    pr = 0; pc = 0; fd_exp = 1'b0;
  endtask

  // One clock of stimulus plus model update; called just after a falling edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d, output logic fired);
    logic r, exp_v, ofire;
    logic [199:0] w;
    case (mode)
      0: r = 1'b1;
      1: r = ($urandom_range(0, 3) != 0);
      2: begin
        if (!hold_started && q.size() != 0) begin
          hold_started = 1'b1;
          hold_left = 10;
        end
        r = (hold_left == 0);
        if (hold_left > 0) hold_left--;
      end
      default: r = 1'b0;
    endcase
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; is[k] = 1'b0; id[k] = 8'h00; orr[k] = 1'b0;
    end
    iv[cur] = v; is[cur] = s; id[cur] = d; orr[cur] = r;
    #1;
    exp_v = (q.size() != 0);
    check("out_valid", 200'(ov[cur]), 200'(exp_v));
    if (exp_v) check("out_window", obs_win(), q[0]);
    check("frame_done", 200'(fd[cur]), 200'(fd_exp));
    check("in_ready", 200'(ir[cur]), 200'(!exp_v || r));
    fired = v && (!exp_v || r);
    ofire = exp_v && r;
    if (ofire) begin
      if (use_max) check("pool_max", 200'(win_max(obs_win())), 200'(mx_q.pop_front()));
      void'(q.pop_front());
    end
    fd_exp = 1'b0;
    if (fired) begin
      if (s) begin
        pr = 0; pc = 0;
      end
      img[pr][pc] = d;
      if (pr == H - 1 && pc == W - 1) fd_exp = 1'b1;
      if (pr % F == F - 1 && pc % F == F - 1 && pr < (H / F) * F && pc < (W / F) * F) begin
        w = '0;
        for (int i = 0; i < F; i++)
          for (int j = 0; j < F; j++)
            w[(i*F+j)*8 +: 8] = img[pr-F+1+i][pc-F+1+j];
        q.push_back(w);
      end
      pc++;
      if (pc == W) begin
        pc = 0;
        pr++;
        if (pr == H) pr = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    logic f;
    int n;
    f = 1'b0;
    if (mode == 1 && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'h00, f);
    n = 0;
    f = 1'b0;
    while (!f && n < 200) begin
      step(1'b1, s, d, f);
      n++;
    end
    if (!f) begin
      total++;
      bad++;
      $display("FAIL accept_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic drain();
    logic f;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step(1'b0, 1'b0, 8'h00, f);
      n++;
    end
    step(1'b0, 1'b0, 8'h00, f);
    check("drained", 200'(q.size()), 200'(0));
  endtask

  initial begin
    logic f;
    logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; is[k] = 1'b0; id[k] = 8'h00; orr[k] = 1'b0;
    end
    @(negedge clk);

    // F=2 W=4 H=4 raster 0..15, always ready; pooled maxima 5,7,13,15
    sel(0); mode = 0; reset_all();
    use_max = 1'b1; mx_q = '{5, 7, 13, 15};
    for (int p = 0; p < 16; p++) send(8'(p), 1'b0);
    drain();
    use_max = 1'b0;
    check("max_all_seen", 200'(mx_q.size()), 200'(0));

    // same stream, consumer stalls 10 cycles on the first window
    reset_all(); mode = 2; hold_started = 1'b0; hold_left = 0;
    for (int p = 0; p < 16; p++) send(8'(p), 1'b0);
    drain();

    // F=2 W=5 H=5: col 4 and row 4 discarded
    sel(1); mode = 0; reset_all();
    for (int p = 0; p < 25; p++) send(8'(p), 1'b0);
    drain();

    // sof on the 7th pixel abandons the partial band
    reset_all();
    for (int p = 0; p < 6; p++) send(8'(200 + p), 1'b0);
    for (int p = 0; p < 25; p++) send(8'(50 + p), (p == 0));
    drain();

    // default config, random data and handshakes, signed extremes in window 0
    sel(2); mode = 1; reset_all();
    for (int fr = 0; fr < 2; fr++) begin
      for (int p = 0; p < 900; p++) begin
        d = 8'($urandom);
        if (fr == 0 && p == 0) d = 8'h80;
        if (fr == 0 && p == 4 * 30 + 4) d = 8'h7F;
        send(d, (fr == 1 && p == 0));
      end
    end
    drain();

    // reset while a window is held, then a clean frame
    sel(0); mode = 3; reset_all();
    for (int p = 0; p < 6; p++) send(8'(40 + p), 1'b0);
    step(1'b0, 1'b0, 8'h00, f);
    reset_all();
    mode = 0;
    for (int p = 0; p < 16; p++) send(8'(16 + p), 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
